// File: rtl/sipo_frame_router.sv
// Serial/word-gather frame router: deserialises LSB-first frames into AES, key or memory-write registers.
// Latency: valid is visible the cycle after the last bit/word (or parity bit, with SIPO_PARITY_EN) is accepted.
// Backpressure: each output holds valid and stable data until its ready; no new frame starts until that handshake.
module sipo_frame_router #(
    parameter int AES_DATA_WIDTH = 128,
    parameter int KEY_DATA_WIDTH = 128,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_OUT_WIDTH  = MEM_ADDR_WIDTH + MEM_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                instruction,
    input  logic                      data_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
    input  logic                      mem_valid_i,
    output logic                      mem_ready_o,
    output logic [AES_DATA_WIDTH-1:0] aes_data_o,
    output logic                      aes_valid_o,
    input  logic                      aes_ready_i,
    output logic [KEY_DATA_WIDTH-1:0] key_data_o,
    output logic                      key_valid_o,
    input  logic                      key_ready_i,
    output logic [MEM_OUT_WIDTH-1:0]  mem_data_o,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic                      busy_o,
    output logic                      frame_err_o
);

    localparam int AK_W     = (AES_DATA_WIDTH > KEY_DATA_WIDTH) ? AES_DATA_WIDTH : KEY_DATA_WIDTH;
    localparam int SR_W     = (AK_W > MEM_OUT_WIDTH) ? AK_W : MEM_OUT_WIDTH;
    localparam int SR_IDX_W = $clog2(SR_W);
    localparam int CNT_W    = $clog2(SR_W + 1);
    localparam int WORDS    = AES_DATA_WIDTH / MEM_DATA_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_WLOAD  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef SIPO_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    localparam logic [1:0] M_AES  = 2'd0;
    localparam logic [1:0] M_MEM  = 2'd1;
    localparam logic [1:0] M_WORD = 2'd2;
    localparam logic [1:0] M_KEY  = 2'd3;

    logic [2:0]                state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SR_W-1:0]           sr_q, sr_d;
    logic [AES_DATA_WIDTH-1:0] aes_data_q, aes_data_d;
    logic [KEY_DATA_WIDTH-1:0] key_data_q, key_data_d;
    logic [MEM_OUT_WIDTH-1:0]  mem_data_q, mem_data_d;
    logic                      aes_vld_q, aes_vld_d;
    logic                      key_vld_q, key_vld_d;
    logic                      mem_vld_q, mem_vld_d;
`ifdef SIPO_PARITY_EN
    logic                      par_q, par_d;
    logic                      err_q, err_d;
`endif

    logic [SR_IDX_W-1:0] top_idx;
    logic [SR_IDX_W-1:0] word_base;
    logic [SR_W-1:0]     sr_shift;
    logic [SR_W-1:0]     load_src;
    logic                load_en;
    logic                bit_acc;
    logic                word_acc;
    logic                hs;

`ifdef SIPO_PARITY_EN
    assign data_ready_o = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign frame_err_o  = err_q;
`else
    assign data_ready_o = (state_q == S_SHIFT);
    assign frame_err_o  = 1'b0;
`endif
    assign mem_ready_o = (state_q == S_WLOAD);
    assign busy_o      = (state_q != S_IDLE);
    assign bit_acc     = data_valid_i & data_ready_o;
    assign word_acc    = mem_valid_i & mem_ready_o;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        aes_data_d = aes_data_q;
        key_data_d = key_data_q;
        mem_data_d = mem_data_q;
        aes_vld_d  = aes_vld_q;
        key_vld_d  = key_vld_q;
        mem_vld_d  = mem_vld_q;
        load_en    = 1'b0;
        load_src   = sr_q;
        hs         = 1'b0;
`ifdef SIPO_PARITY_EN
        par_d      = par_q;
        err_d      = 1'b0;
`endif
        case (mode_q)
            M_MEM:   top_idx = SR_IDX_W'(MEM_OUT_WIDTH - 1);
            M_KEY:   top_idx = SR_IDX_W'(KEY_DATA_WIDTH - 1);
            default: top_idx = SR_IDX_W'(AES_DATA_WIDTH - 1);
        endcase
        // New bit enters at the top of the N-bit field so the first bit ends up at bit 0.
        sr_shift          = sr_q >> 1;
        sr_shift[top_idx] = data_i;
        word_base         = SR_IDX_W'(int'(cnt_q) * MEM_DATA_WIDTH);

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    mode_d  = instruction;
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = (instruction == M_WORD) ? S_WLOAD : S_SHIFT;
`ifdef SIPO_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (bit_acc) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SIPO_PARITY_EN
                    par_d = par_q ^ data_i;
                    if (cnt_q == CNT_W'(top_idx)) state_d = S_PARITY;
`else
                    if (cnt_q == CNT_W'(top_idx)) begin
                        load_en  = 1'b1;
                        load_src = sr_shift;
                        state_d  = S_HOLD;
                    end
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (bit_acc) begin
                    if ((par_q ^ data_i) == 1'b0) begin
                        load_en = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        sr_d    = '0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_WLOAD: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (word_acc) begin
                    sr_d[word_base +: MEM_DATA_WIDTH] = mem_data_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORDS - 1)) begin
                        load_en  = 1'b1;
                        load_src = sr_d;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                case (mode_q)
                    M_MEM: begin
                        hs = mem_vld_q & mem_ready_i;
                        if (hs) mem_vld_d = 1'b0;
                    end
                    M_KEY: begin
                        hs = key_vld_q & key_ready_i;
                        if (hs) key_vld_d = 1'b0;
                    end
                    default: begin
                        hs = aes_vld_q & aes_ready_i;
                        if (hs) aes_vld_d = 1'b0;
                    end
                endcase
                if (hs) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    // Key material must not linger in the shared shift register.
                    if (mode_q == M_KEY) sr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            case (mode_q)
                M_MEM: begin
                    mem_data_d = load_src[MEM_OUT_WIDTH-1:0];
                    mem_vld_d  = 1'b1;
                end
                M_KEY: begin
                    key_data_d = load_src[KEY_DATA_WIDTH-1:0];
                    key_vld_d  = 1'b1;
                end
                default: begin
                    aes_data_d = load_src[AES_DATA_WIDTH-1:0];
                    aes_vld_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= M_AES;
            cnt_q      <= '0;
            sr_q       <= '0;
            aes_data_q <= '0;
            key_data_q <= '0;
            mem_data_q <= '0;
            aes_vld_q  <= 1'b0;
            key_vld_q  <= 1'b0;
            mem_vld_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            aes_data_q <= aes_data_d;
            key_data_q <= key_data_d;
            mem_data_q <= mem_data_d;
            aes_vld_q  <= aes_vld_d;
            key_vld_q  <= key_vld_d;
            mem_vld_q  <= mem_vld_d;
`ifdef SIPO_PARITY_EN
            par_q      <= par_d;
            err_q      <= err_d;
`endif
        end
    end

    assign aes_data_o  = aes_data_q;
    assign key_data_o  = key_data_q;
    assign mem_data_o  = mem_data_q;
    assign aes_valid_o = aes_vld_q;
    assign key_valid_o = key_vld_q;
    assign mem_valid_o = mem_vld_q;

endmodule

// File: tb/tb_sipo_frame_router.sv
// Scoreboarded bench for sipo_frame_router; frames get an even-parity bit when SIPO_PARITY_EN is defined.
module tb_sipo_frame_router;
    localparam int AW  = 128;
    localparam int KW  = 128;
    localparam int MAW = 8;
    localparam int MDW = 32;
    localparam int MOW = MAW + MDW;
`ifdef SIPO_PARITY_EN
    localparam int PERIOD = AW + 3;
`else
    localparam int PERIOD = AW + 2;
`endif

    logic           clk, rst, en;
    logic [1:0]     instruction;
    logic           data_i, data_valid_i, data_ready_o;
    logic [MDW-1:0] mem_data_i;
    logic           mem_valid_i, mem_ready_o;
    logic [AW-1:0]  aes_data_o;
    logic           aes_valid_o, aes_ready_i;
    logic [KW-1:0]  key_data_o;
    logic           key_valid_o, key_ready_i;
    logic [MOW-1:0] mem_data_o;
    logic           mem_valid_o, mem_ready_i;
    logic           busy_o, frame_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aes_vld_cycles = 0;
    int aes_hs_last = -1;
    int aes_hs_prev = -1;
    logic [AW-1:0]  aes_exp_q[$];
    logic [KW-1:0]  key_exp_q[$];
    logic [MOW-1:0] mem_exp_q[$];
    logic [AW-1:0]  aes_e;
    logic [KW-1:0]  key_e;
    logic [MOW-1:0] mem_e;

    sipo_frame_router #(
        .AES_DATA_WIDTH(AW), .KEY_DATA_WIDTH(KW), .MEM_ADDR_WIDTH(MAW),
        .MEM_DATA_WIDTH(MDW), .MEM_OUT_WIDTH(MOW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .instruction(instruction),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .aes_data_o(aes_data_o), .aes_valid_o(aes_valid_o), .aes_ready_i(aes_ready_i),
        .key_data_o(key_data_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
        .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Handshakes are judged shortly after the falling edge, once the bench has driven readies.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (aes_valid_o) aes_vld_cycles++;
            if (aes_valid_o && aes_ready_i) begin
                checks++;
                aes_hs_prev = aes_hs_last;
                aes_hs_last = cyc;
                if (aes_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL aes_unexpected: got %h, none expected", aes_data_o);
                end else begin
                    aes_e = aes_exp_q.pop_front();
                    if (aes_data_o !== aes_e) begin
                        errors++;
                        $display("FAIL aes_data: got %h, expected %h", aes_data_o, aes_e);
                    end
                end
            end
            if (key_valid_o && key_ready_i) begin
                checks++;
                if (key_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_unexpected: got %h, none expected", key_data_o);
                end else begin
                    key_e = key_exp_q.pop_front();
                    if (key_data_o !== key_e) begin
                        errors++;
                        $display("FAIL key_data: got %h, expected %h", key_data_o, key_e);
                    end
                end
            end
            if (mem_valid_o && mem_ready_i) begin
                checks++;
                if (mem_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: got %h, none expected", mem_data_o);
                end else begin
                    mem_e = mem_exp_q.pop_front();
                    if (mem_data_o !== mem_e) begin
                        errors++;
                        $display("FAIL mem_data: got %h, expected %h", mem_data_o, mem_e);
                    end
                end
            end
        end
    end

    // Called at a falling edge; data_ready_o then predicts acceptance at the next rising edge.
    task automatic send_bits(input logic [255:0] v, input int n);
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < n && guard < 1000) begin
            data_i       = v[i];
            data_valid_i = 1'b1;
            acc          = data_ready_o;
            @(negedge clk);
            if (acc) i++;
            else guard++;
        end
        data_valid_i = 1'b0;
        checks++;
        if (guard >= 1000) begin
            errors++;
            $display("FAIL send_timeout: sent %0d bits, required %0d", i, n);
        end
    endtask

    task automatic send_frame(input logic [255:0] v, input int n);
        logic [255:0] vv = v;
`ifdef SIPO_PARITY_EN
        logic p = 1'b0;
        for (int k = 0; k < n; k++) p ^= v[k];
        vv[n] = p;
        send_bits(vv, n + 1);
`else
        send_bits(vv, n);
`endif
    endtask

    task automatic start(input logic [1:0] m);
        en          = 1'b1;
        instruction = m;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (aes_data_o !== '0 || key_data_o !== '0 || mem_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: aes %h key %h mem %h, required 0", aes_data_o, key_data_o, mem_data_o);
        end
        checks++;
        if ({aes_valid_o, key_valid_o, mem_valid_o, data_ready_o, mem_ready_o, busy_o, frame_err_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {aes_valid_o, key_valid_o, mem_valid_o, data_ready_o, mem_ready_o, busy_o, frame_err_o});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_back_to_back();
        logic [AW-1:0] v1 = 128'h00112233445566778899AABBCCDDEEFF;
        logic [AW-1:0] v2 = ~v1;
        aes_ready_i    = 1'b1;
        aes_vld_cycles = 0;
        aes_exp_q.push_back(v1);
        aes_exp_q.push_back(v2);
        start(2'd0);
        send_frame({128'b0, v1}, AW);
        send_frame({128'b0, v2}, AW);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (aes_vld_cycles != 2) begin
            errors++;
            $display("FAIL m0_valid_cycles: got %0d, required 2", aes_vld_cycles);
        end
        checks++;
        if (aes_hs_last - aes_hs_prev != PERIOD) begin
            errors++;
            $display("FAIL m0_period: got %0d cycles, required %0d", aes_hs_last - aes_hs_prev, PERIOD);
        end
        checks++;
        if (key_data_o !== '0 || mem_data_o !== '0) begin
            errors++;
            $display("FAIL m0_other_channels: key %h mem %h, required 0", key_data_o, mem_data_o);
        end
        checks++;
        if (aes_data_o !== v2 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL m0_persist: aes %h busy %b, required %h busy 0", aes_data_o, busy_o, v2);
        end
    endtask

    task automatic test_mode1_stall();
        logic [MOW-1:0] f = {8'hA5, 32'hDEADBEEF};
        mem_ready_i = 1'b0;
        mem_exp_q.push_back(f);
        start(2'd1);
        send_frame({216'b0, f}, MOW);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_valid_o !== 1'b1 || mem_data_o !== 40'hA5DEADBEEF || data_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL m1_stall[%0d]: valid %b data %h rdy %b, required 1 a5deadbeef 0",
                         k, mem_valid_o, mem_data_o, data_ready_o);
            end
            @(negedge clk);
        end
        mem_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_valid_o !== 1'b0 || busy_o !== 1'b0 || mem_data_o !== 40'hA5DEADBEEF) begin
            errors++;
            $display("FAIL m1_release: valid %b busy %b data %h, required 0 0 a5deadbeef",
                     mem_valid_o, busy_o, mem_data_o);
        end
    endtask

    task automatic test_mode2_gapped();
        logic acc;
        int guard;
        logic [AW-1:0] exp_blk = 128'h44444444333333332222222211111111;
        aes_ready_i = 1'b1;
        aes_exp_q.push_back(exp_blk);
        start(2'd2);
        @(negedge clk);
        instruction = 2'd0;
        checks++;
        if (mem_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL m2_ready: mem_ready %b data_ready %b, required 1 0", mem_ready_o, data_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            mem_valid_i = 1'b0;
            repeat (2) @(negedge clk);
            mem_data_i  = 32'(32'h11111111 * (k + 1));
            mem_valid_i = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                acc = mem_ready_o;
                @(negedge clk);
                guard++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL m2_word_timeout: word %0d not accepted", k);
            end
        end
        mem_valid_i = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (aes_data_o !== exp_blk || busy_o !== 1'b0 || mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL m2_result: aes %h busy %b mem_ready %b, required %h 0 0",
                     aes_data_o, busy_o, mem_ready_o, exp_blk);
        end
    endtask

    task automatic test_abort_scrub();
        logic [KW-1:0] kf = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0001;
        key_ready_i = 1'b1;
        start(2'd3);
        send_bits({192'b0, 64'h0F0F_1234_5678_9ABC}, 60);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dut.sr_q !== '0) begin
            errors++;
            $display("FAIL abort_clear: busy %b sr %h, required 0 0", busy_o, dut.sr_q);
        end
        repeat (3) begin
            checks++;
            if (key_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_valid: key_valid %b, required 0", key_valid_o);
            end
            @(negedge clk);
        end
        key_exp_q.push_back(kf);
        start(2'd3);
        send_frame({128'b0, kf}, KW);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (key_data_o !== kf || dut.sr_q !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL key_scrub: key %h sr %h busy %b, required %h 0 0", key_data_o, dut.sr_q, busy_o, kf);
        end
    endtask

    task automatic test_reset_midframe();
        logic [AW-1:0] v3 = 128'hCAFEF00D_0123_4567_89AB_CDEF_DEAD_BEEF;
        aes_ready_i = 1'b1;
        start(2'd0);
        send_bits({128'b0, ~v3}, 100);
        rst = 1'b0;
        #1;
        checks++;
        if (aes_data_o !== '0 || key_data_o !== '0 || mem_data_o !== '0 || dut.sr_q !== '0) begin
            errors++;
            $display("FAIL midreset_data: aes %h key %h mem %h sr %h, required 0",
                     aes_data_o, key_data_o, mem_data_o, dut.sr_q);
        end
        checks++;
        if ({aes_valid_o, key_valid_o, mem_valid_o, data_ready_o, mem_ready_o, busy_o, frame_err_o} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %b, required 0000000",
                     {aes_valid_o, key_valid_o, mem_valid_o, data_ready_o, mem_ready_o, busy_o, frame_err_o});
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        aes_exp_q.push_back(v3);
        start(2'd0);
        send_frame({128'b0, v3}, AW);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (aes_data_o !== v3 || key_data_o !== '0 || mem_data_o !== '0) begin
            errors++;
            $display("FAIL midreset_fresh: aes %h key %h mem %h, required %h 0 0",
                     aes_data_o, key_data_o, mem_data_o, v3);
        end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        logic [AW-1:0] v = 128'h1;
        logic [AW-1:0] before;
        logic [255:0]  fr;
        int err_cycles = 0;
        int vld_cycles = 0;
        aes_ready_i = 1'b1;
        before = aes_data_o;
        fr = {128'b0, v};
        fr[AW] = 1'b0;
        start(2'd0);
        send_bits(fr, AW + 1);
        en = 1'b0;
        repeat (4) begin
            if (frame_err_o) err_cycles++;
            if (aes_valid_o) vld_cycles++;
            @(negedge clk);
        end
        checks++;
        if (err_cycles != 1 || vld_cycles != 0 || aes_data_o !== before) begin
            errors++;
            $display("FAIL parity_bad: err %0d valid %0d aes %h, required 1 0 %h",
                     err_cycles, vld_cycles, aes_data_o, before);
        end
        aes_exp_q.push_back(v);
        err_cycles = 0;
        fr[AW] = 1'b1;
        start(2'd0);
        send_bits(fr, AW + 1);
        en = 1'b0;
        repeat (3) begin
            if (frame_err_o) err_cycles++;
            @(negedge clk);
        end
        checks++;
        if (err_cycles != 0 || aes_data_o !== v) begin
            errors++;
            $display("FAIL parity_good: err %0d aes %h, required 0 %h", err_cycles, aes_data_o, v);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        en = 1'b0;
        instruction = 2'd0;
        data_i = 1'b0;
        data_valid_i = 1'b0;
        mem_data_i = '0;
        mem_valid_i = 1'b0;
        aes_ready_i = 1'b0;
        key_ready_i = 1'b0;
        mem_ready_i = 1'b0;
        test_reset();
        test_mode0_back_to_back();
        test_mode1_stall();
        test_mode2_gapped();
        test_abort_scrub();
        test_reset_midframe();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (aes_exp_q.size() != 0 || key_exp_q.size() != 0 || mem_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending aes %0d key %0d mem %0d, required 0 0 0",
                     aes_exp_q.size(), key_exp_q.size(), mem_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
